// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   FIFO controller for a 1r1w SRAM macro (registered, negedge-evaluated
//   read). It owns the write/read pointers and the SRAM occupancy. A
//   2-entry output stage hides the one-cycle read latency, so the FIFO
//   sustains one push and one pop per cycle.
//
// Optional feature: define FIFO_LEVEL_EN to add the `count` port, which
//   reports the total number of entries held (SRAM + in flight + stage).
//
// Ports
//   clk, rst_n                 clock (shared with SRAM clk0/clk1); sync active-low reset
//   in_data/in_valid/in_ready  push side (valid/ready)
//   out_data/out_valid/out_ready pop side (valid/ready)
//   count                      entries held (FIFO_LEVEL_EN only)
//   sram_csb0/addr0/din0       SRAM write port
//   sram_csb1/addr1/dout1      SRAM read port
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   count,
`endif
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   sram_cnt;
  logic                  pend;
  logic [1:0]            ost_cnt;
  logic [DATA_WIDTH-1:0] ost0, ost1;   // ost0 is the head
  logic                  push, pop, issue;

  // in_ready looks only at registered state; a same-cycle read issue
  // does not free a slot until the next cycle.
  assign in_ready  = rst_n && (sram_cnt != FULL);
  assign push      = in_valid && in_ready;
  assign out_valid = (ost_cnt != 2'd0);
  assign out_data  = ost0;
  assign pop       = out_valid && out_ready;

  // Issue only if the stage still has room once this read and any read
  // already in flight land: ost_cnt + pend - pop < 2 (kept non-negative).
  assign issue = rst_n && (sram_cnt != '0) &&
                 (({1'b0, ost_cnt} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

  // Pointers only meet when the SRAM is empty or full, so a write and a
  // read can never target the same address in one cycle.
  assign sram_csb0  = !push;
  assign sram_addr0 = wr_ptr;
  assign sram_din0  = push ? in_data : '0;
  assign sram_csb1  = !issue;
  assign sram_addr1 = rd_ptr;

`ifdef FIFO_LEVEL_EN
  assign count = sram_cnt + {{ADDR_WIDTH{1'b0}}, pend} + {{(ADDR_WIDTH-1){1'b0}}, ost_cnt};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      pend     <= 1'b0;
      ost_cnt  <= 2'd0;
      ost0     <= '0;
      ost1     <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      sram_cnt <= sram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
      pend     <= issue;
      ost_cnt  <= ost_cnt + {1'b0, pend} - {1'b0, pop};

      // Read data is valid only at the edge ending a pend cycle. The
      // captured word goes into the first free slot after this pop.
      unique case ({pop, pend})
        2'b10: ost0 <= ost1;
        2'b01: begin
          if (ost_cnt == 2'd0) ost0 <= sram_dout1;
          else                 ost1 <= sram_dout1;
        end
        2'b11: begin
          if (ost_cnt == 2'd1) ost0 <= sram_dout1;
          else begin
            ost0 <= ost1;
            ost1 <= sram_dout1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
module tb_sram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef FIFO_LEVEL_EN
  logic [10:0] count;
`endif
  logic       sram_csb0, sram_csb1;
  logic [9:0] sram_addr0, sram_addr1;
  logic [7:0] sram_din0, sram_dout1;

  sram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef FIFO_LEVEL_EN
    .count(count),
`endif
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  // SRAM model: ports registered at posedge, read data driven at negedge.
  logic [7:0] mem [0:1023];
  logic [9:0] rd_addr_q;
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) rd_addr_q <= sram_addr1;
  end
  always @(negedge clk) sram_dout1 <= mem[rd_addr_q];

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int npush, npop, vcnt, first_v, last_v, wraps;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Same-address write/read in one cycle must never happen.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && !sram_csb0 && !sram_csb1) begin
      tests++;
      assert (sram_addr0 !== sram_addr1) else begin
        fails++;
        $error("FAIL collision: addr0 %0h addr1 %0h", sram_addr0, sram_addr1);
      end
    end
  end

  // One clock cycle with scoreboard: inputs driven at posedge+1, handshake
  // evaluated at negedge against the reference queue.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    @(negedge clk);
`ifdef FIFO_LEVEL_EN
    chk("count", 32'(count), 32'(q.size()));
`endif
    if (out_valid) begin
      vcnt++;
      if (first_v < 0) first_v = cyc_n;
      last_v = cyc_n;
    end
    if (out_valid && out_ready) begin
      chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("data", 32'(out_data), 32'(q.pop_front()));
      npop++;
    end
    if (in_valid && in_ready) begin
      q.push_back(in_data);
      npush++;
      if (sram_addr0 == 10'h3FF) wraps++;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
    npush = 0; npop = 0; vcnt = 0; first_v = -1; last_v = -1; wraps = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_out_data", 32'(out_data), 32'd0);
    chk("rel_addr0", 32'(sram_addr0), 32'd0);
    chk("rel_addr1", 32'(sram_addr1), 32'd0);
    chk("rel_din0", 32'(sram_din0), 32'd0);
    chk("rel_csb1", 32'(sram_csb1), 32'd1);
`ifdef FIFO_LEVEL_EN
    chk("rel_count", 32'(count), 32'd0);
`endif

    // Single word: visible in cycle 3 only.
    cyc(1'b1, 8'hA5, 1'b1); chk("sw_v1", 32'(out_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1); chk("sw_v2", 32'(out_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1); chk("sw_v3", 32'(out_valid), 32'd1);
    chk("sw_d3", 32'(out_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1); chk("sw_v4", 32'(out_valid), 32'd0);

    // Fill: exactly DEPTH+2 accepted.
    npush = 0;
    for (int i = 0; i < 1030; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("fill_pushes", 32'(npush), 32'd1026);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
`ifdef FIFO_LEVEL_EN
    chk("fill_count", 32'(count), 32'd1026);
`endif
    npop = 0;
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 1100; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_pops", 32'(npop), 32'd1026);
    chk("drain_empty", 32'(q.size()), 32'd0);

    // Streaming: 256 back-to-back words, out_valid run starts 3 cycles in.
    vcnt = 0; first_v = -1; last_v = -1;
    begin
      int s;
      s = cyc_n;
      for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
      chk("st_vcnt", 32'(vcnt), 32'd256);
      chk("st_first", 32'(first_v), 32'(s + 3));
      chk("st_last", 32'(last_v), 32'(s + 258));
    end

    // Random traffic with backpressure, 5000 words.
    npush = 0; wraps = 0;
    for (int i = 0; i < 40000 && npush < 5000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    chk("rnd_pushes", 32'(npush), 32'd5000);
    for (int i = 0; i < 1100 && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("rnd_empty", 32'(q.size()), 32'd0);
    chk("rnd_wraps", 32'(wraps >= 4), 32'd1);

    // Reset mid-operation: 10 held with a read in flight.
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
`ifdef FIFO_LEVEL_EN
    chk("pre_rst_count", 32'(count), 32'd10);
`endif
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_csb0", 32'(sram_csb0), 32'd1);
    chk("mid_rst_csb1", 32'(sram_csb1), 32'd1);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    q.delete();
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_csb0", 32'(sram_csb0), 32'd1);
    chk("post_rst_csb1", 32'(sram_csb1), 32'd1);
`ifdef FIFO_LEVEL_EN
    chk("post_rst_count", 32'(count), 32'd0);
`endif
    cyc(1'b1, 8'h3C, 1'b1); chk("pr_v1", 32'(out_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1); chk("pr_v2", 32'(out_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1); chk("pr_v3", 32'(out_valid), 32'd1);
    chk("pr_d3", 32'(out_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1); chk("pr_v4", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
